// File: rtl/scr1_pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// scr1_pipe_fetch_queue
// DEPTH-entry instruction fetch queue between the IFU (producer) and the IDU
// (consumer). Each entry carries {instr, pc, err}. The EXU new-PC request
// flushes the queue. A pushed IMEM fault sets a sticky lock that stops the
// queue from accepting further fetches until the next flush.
//
// Ports
//   clk, pipe_rst      pipeline clock, asynchronous active-high reset
//   ifu2fq_*_i         IFU push side: valid, instruction, PC, fault tag
//   fq2ifu_rdy_o       queue can take a push this cycle
//   fq2idu_*_o         head entry: valid, instruction, PC, fault tag
//   idu2fq_rdy_i       IDU consumes the head this cycle
//   exu2fq_flush_i     flush (new PC request), highest priority
//   fq_count_o         occupancy
//   fq_afull_o         occupancy >= AFULL_LVL
//   fq_lock_o          fault lock active
// ---------------------------------------------------------------------------
module scr1_pipe_fetch_queue #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   pipe_rst,
  input  logic                   ifu2fq_vd_i,
  input  logic [DATA_W-1:0]      ifu2fq_instr_i,
  input  logic [ADDR_W-1:0]      ifu2fq_pc_i,
  input  logic                   ifu2fq_err_i,
  output logic                   fq2ifu_rdy_o,
  output logic                   fq2idu_vd_o,
  output logic [DATA_W-1:0]      fq2idu_instr_o,
  output logic [ADDR_W-1:0]      fq2idu_pc_o,
  output logic                   fq2idu_err_o,
  input  logic                   idu2fq_rdy_i,
  input  logic                   exu2fq_flush_i,
  output logic [$clog2(DEPTH):0] fq_count_o,
  output logic                   fq_afull_o,
  output logic                   fq_lock_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic              err_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              lock_q,   lock_d;

  logic              push_s;
  logic              pop_s;

  // Ready depends only on registered state, so there is no IDU-to-IFU path.
  assign fq2ifu_rdy_o   = (count_q != FULL_CNT) & ~lock_q;
  assign fq2idu_vd_o    = (count_q != EMPTY_CNT);
  assign fq2idu_instr_o = instr_q[rd_ptr_q];
  assign fq2idu_pc_o    = pc_q[rd_ptr_q];
  assign fq2idu_err_o   = err_q[rd_ptr_q];
  assign fq_count_o     = count_q;
  assign fq_afull_o     = (count_q >= AFULL_CNT);
  assign fq_lock_o      = lock_q;

  // A flush cycle discards both the push and the pop.
  assign push_s = ifu2fq_vd_i & fq2ifu_rdy_o & ~exu2fq_flush_i;
  assign pop_s  = fq2idu_vd_o & idu2fq_rdy_i & ~exu2fq_flush_i;

  // Next-state for pointers, occupancy and the fault lock.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lock_d   = lock_q;
    if (exu2fq_flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = EMPTY_CNT;
      lock_d   = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Once set, the lock holds until a flush or reset.
      if (push_s & ifu2fq_err_i) begin
        lock_d = 1'b1;
      end else begin
        lock_d = lock_q;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge pipe_rst) begin
    if (pipe_rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= EMPTY_CNT;
      lock_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
    end
  end

  // Entry storage; written on accepted push only, untouched by flush.
  always_ff @(posedge clk or posedge pipe_rst) begin
    if (pipe_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= {DATA_W{1'b0}};
        pc_q[i]    <= {ADDR_W{1'b0}};
        err_q[i]   <= 1'b0;
      end
    end else if (push_s) begin
      instr_q[wr_ptr_q] <= ifu2fq_instr_i;
      pc_q[wr_ptr_q]    <= ifu2fq_pc_i;
      err_q[wr_ptr_q]   <= ifu2fq_err_i;
    end
  end

endmodule

// File: tb/tb_scr1_pipe_fetch_queue.sv
// ---------------------------------------------------------------------------
// Bench for scr1_pipe_fetch_queue. Three queues (DEPTH 2, 4, 8) share one
// stimulus stream. Each has a queue-based reference model that is checked on
// every falling edge; the DEPTH=4 instance also gets directed checks.
// ---------------------------------------------------------------------------
module tb_scr1_pipe_fetch_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vd;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        err;
  logic        idu_rdy;
  logic        flush;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_q
    localparam int D  = (g == 0) ? 2 : ((g == 1) ? 4 : 8);
    localparam int CW = $clog2(D) + 1;

    logic          rdy_w, vd_w, err_w, afull_w, lock_w;
    logic [31:0]   instr_w, pc_w;
    logic [CW-1:0] cnt_w;

    scr1_pipe_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(D)) u_dut (
      .clk            (clk),
      .pipe_rst       (rst),
      .ifu2fq_vd_i    (vd),
      .ifu2fq_instr_i (instr),
      .ifu2fq_pc_i    (pc),
      .ifu2fq_err_i   (err),
      .fq2ifu_rdy_o   (rdy_w),
      .fq2idu_vd_o    (vd_w),
      .fq2idu_instr_o (instr_w),
      .fq2idu_pc_o    (pc_w),
      .fq2idu_err_o   (err_w),
      .idu2fq_rdy_i   (idu_rdy),
      .exu2fq_flush_i (flush),
      .fq_count_o     (cnt_w),
      .fq_afull_o     (afull_w),
      .fq_lock_o      (lock_w)
    );

    entry_t sbq[$];
    logic   lock_m = 1'b0;

    // Reference model: accepted pushes enter the scoreboard, pops leave it.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        sbq.delete();
        lock_m <= 1'b0;
      end else if (flush) begin
        sbq.delete();
        lock_m <= 1'b0;
      end else begin
        case ({vd && (sbq.size() != D) && !lock_m, (sbq.size() != 0) && idu_rdy})
          2'b10: begin
            sbq.push_back({instr, pc, err});
            if (err) lock_m <= 1'b1;
          end
          2'b01: void'(sbq.pop_front());
          2'b11: begin
            void'(sbq.pop_front());
            sbq.push_back({instr, pc, err});
            if (err) lock_m <= 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
      chk($sformatf("d%0d_vd", D),    64'(vd_w),    64'(sbq.size() != 0));
      chk($sformatf("d%0d_rdy", D),   64'(rdy_w),   64'((sbq.size() != D) && !lock_m));
      chk($sformatf("d%0d_cnt", D),   64'(cnt_w),   64'(sbq.size()));
      chk($sformatf("d%0d_afull", D), 64'(afull_w), 64'(sbq.size() >= D - 1));
      chk($sformatf("d%0d_lock", D),  64'(lock_w),  64'(lock_m));
      if (sbq.size() != 0) begin
        chk($sformatf("d%0d_head_pc", D),    64'(pc_w),    64'(sbq[0].pc));
        chk($sformatf("d%0d_head_instr", D), 64'(instr_w), 64'(sbq[0].instr));
        chk($sformatf("d%0d_head_err", D),   64'(err_w),   64'(sbq[0].err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vd"},    64'(gen_q[1].vd_w),    64'h0);
    chk({tag, "_rdy"},   64'(gen_q[1].rdy_w),   64'h1);
    chk({tag, "_instr"}, 64'(gen_q[1].instr_w), 64'h0);
    chk({tag, "_pc"},    64'(gen_q[1].pc_w),    64'h0);
    chk({tag, "_err"},   64'(gen_q[1].err_w),   64'h0);
    chk({tag, "_cnt"},   64'(gen_q[1].cnt_w),   64'h0);
    chk({tag, "_afull"}, 64'(gen_q[1].afull_w), 64'h0);
    chk({tag, "_lock"},  64'(gen_q[1].lock_w),  64'h0);
  endtask

  initial begin
    rst     = 1'b1;
    vd      = 1'b0;
    instr   = 32'h0;
    pc      = 32'h0;
    err     = 1'b0;
    idu_rdy = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("rst");

    // Fill to full with the consumer stalled, then drain in order.
    for (int k = 0; k < 4; k++) begin
      vd    = 1'b1;
      pc    = 32'h200 + 32'(4 * k);
      instr = 32'hA000_0000 + 32'(k);
      cyc();
      chk("fill_cnt",   64'(gen_q[1].cnt_w),   64'(k + 1));
      chk("fill_afull", 64'(gen_q[1].afull_w), 64'(k >= 2));
    end
    chk("full_rdy", 64'(gen_q[1].rdy_w), 64'h0);
    pc    = 32'h210;
    instr = 32'hA000_0004;
    cyc();
    chk("full_reject_cnt", 64'(gen_q[1].cnt_w), 64'h4);
    vd      = 1'b0;
    idu_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc",    64'(gen_q[1].pc_w),    64'(32'h200 + 32'(4 * k)));
      chk("drain_instr", 64'(gen_q[1].instr_w), 64'(32'hA000_0000 + 32'(k)));
      cyc();
      if (k == 0) chk("rdy_after_pop", 64'(gen_q[1].rdy_w), 64'h1);
    end
    chk("drain_vd", 64'(gen_q[1].vd_w), 64'h0);
    repeat (2) cyc();
    idu_rdy = 1'b0;

    // Streaming: one push and one pop per cycle across pointer wraps.
    vd    = 1'b1;
    pc    = 32'h500;
    instr = 32'hB000_0000;
    cyc();
    chk("stream_first_vd", 64'(gen_q[1].vd_w), 64'h1);
    idu_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pc    = 32'h504 + 32'(4 * k);
      instr = 32'hB000_0001 + 32'(k);
      cyc();
      chk("stream_cnt", 64'(gen_q[1].cnt_w), 64'h1);
      chk("stream_pc",  64'(gen_q[1].pc_w),  64'(32'h504 + 32'(4 * k)));
    end
    vd = 1'b0;
    cyc();
    chk("stream_end_vd", 64'(gen_q[1].vd_w), 64'h0);

    // Flush with a simultaneous push, then a fresh push.
    idu_rdy = 1'b0;
    vd      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc    = 32'h600 + 32'(4 * k);
      instr = 32'hC000_0600 + 32'(k);
      cyc();
    end
    chk("pre_flush_cnt", 64'(gen_q[1].cnt_w), 64'h3);
    flush = 1'b1;
    pc    = 32'h300;
    instr = 32'hC000_0300;
    cyc();
    flush = 1'b0;
    vd    = 1'b0;
    chk("flush_cnt", 64'(gen_q[1].cnt_w), 64'h0);
    chk("flush_vd",  64'(gen_q[1].vd_w),  64'h0);
    chk("flush_rdy", 64'(gen_q[1].rdy_w), 64'h1);
    vd    = 1'b1;
    pc    = 32'h400;
    instr = 32'hC000_0400;
    cyc();
    vd = 1'b0;
    chk("post_flush_vd",    64'(gen_q[1].vd_w),    64'h1);
    chk("post_flush_pc",    64'(gen_q[1].pc_w),    64'h400);
    chk("post_flush_instr", 64'(gen_q[1].instr_w), 64'hC000_0400);

    // Flush with a simultaneous pop.
    idu_rdy = 1'b1;
    flush   = 1'b1;
    cyc();
    flush   = 1'b0;
    idu_rdy = 1'b0;
    chk("flush_pop_cnt", 64'(gen_q[1].cnt_w), 64'h0);
    chk("flush_pop_vd",  64'(gen_q[1].vd_w),  64'h0);
    chk("flush_pop_rdy", 64'(gen_q[1].rdy_w), 64'h1);

    // Fault lock: the faulted entry drains, the IFU stays stalled.
    vd    = 1'b1;
    pc    = 32'h100;
    instr = 32'hD000_0100;
    err   = 1'b0;
    cyc();
    pc    = 32'h104;
    instr = 32'hD000_0104;
    err   = 1'b1;
    cyc();
    chk("lock_set", 64'(gen_q[1].lock_w), 64'h1);
    chk("lock_rdy", 64'(gen_q[1].rdy_w),  64'h0);
    chk("lock_cnt", 64'(gen_q[1].cnt_w),  64'h2);
    pc    = 32'h108;
    instr = 32'hD000_0108;
    err   = 1'b0;
    cyc();
    chk("lock_reject_cnt", 64'(gen_q[1].cnt_w), 64'h2);
    vd      = 1'b0;
    idu_rdy = 1'b1;
    chk("fault_pc0",  64'(gen_q[1].pc_w),  64'h100);
    chk("fault_err0", 64'(gen_q[1].err_w), 64'h0);
    cyc();
    chk("fault_pc1",  64'(gen_q[1].pc_w),  64'h104);
    chk("fault_err1", 64'(gen_q[1].err_w), 64'h1);
    cyc();
    chk("fault_drained_vd", 64'(gen_q[1].vd_w),  64'h0);
    chk("fault_empty_rdy",  64'(gen_q[1].rdy_w), 64'h0);
    cyc();
    chk("fault_hold_rdy", 64'(gen_q[1].rdy_w), 64'h0);
    idu_rdy = 1'b0;
    flush   = 1'b1;
    cyc();
    flush = 1'b0;
    chk("unlock_rdy",  64'(gen_q[1].rdy_w),  64'h1);
    chk("unlock_lock", 64'(gen_q[1].lock_w), 64'h0);

    // Asynchronous reset mid-cycle with count=2 and the lock set.
    vd    = 1'b1;
    pc    = 32'h700;
    instr = 32'hE000_0700;
    err   = 1'b0;
    cyc();
    pc    = 32'h704;
    instr = 32'hE000_0704;
    err   = 1'b1;
    cyc();
    vd  = 1'b0;
    err = 1'b0;
    chk("pre_rst_cnt",  64'(gen_q[1].cnt_w),  64'h2);
    chk("pre_rst_lock", 64'(gen_q[1].lock_w), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    vd    = 1'b1;
    pc    = 32'h800;
    instr = 32'hF000_0800;
    cyc();
    vd = 1'b0;
    chk("post_rst_pc", 64'(gen_q[1].pc_w), 64'h800);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
